dmem_stall_ctrl: RTL
====================

Name: dmem_stall_ctrl

Overview:
- Memory-stage request controller between the processor's memory stage and a multi-cycle, busy/ack-handshaked data memory.
- Converts the single-cycle enable/wr/addr/data request into a memory transaction and holds the pipeline with a stall until the access completes.
- Returns registered read data and flags unaligned or timed-out accesses with a sticky error.
- Issues the end-of-program dump on halt.

Parameters:
- TIMEOUT, 64: max cycles in WAIT before the access is abandoned.
- CNT_W, 7: timeout counter width; must hold TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset. Asserts asynchronously, deasserts synchronously to clk.
- req_en  input  1  memory-stage access request; held stable while stall=1.
- req_wr  input  1  1=store, 0=load.
- req_addr  input  16  byte address; must be even.
- req_wdata  input  16  store data.
- halt  input  1  HALT instruction in the memory stage.
- stall  output  1  freeze PC and upstream pipeline registers.
- done  output  1  one-cycle pulse: access complete, rdata valid.
- rdata  output  16  load result, registered.
- err  output  1  sticky error flag.
- mem_en  output  1  memory enable.
- mem_wr  output  1  memory write.
- mem_addr  output  16  memory address, registered.
- mem_wdata  output  16  memory write data, registered.
- mem_createdump  output  1  one-cycle dump pulse.
- mem_busy  input  1  memory cannot accept a request this cycle.
- mem_ack  input  1  access finished; mem_rdata valid this cycle.
- mem_rdata  input  16  memory read data.

Behaviour:
- Reset (rst=0): state=IDLE, counter=0, err=0. All outputs 0, including rdata=0x0000.
- States: IDLE, ISSUE, WAIT, DONE, HALTED.
- IDLE:
  - req_en=1 with req_addr[0]=1: err<=1, rdata<=0x0000, go to DONE. No memory access.
  - req_en=1 with aligned address: latch wr/addr/wdata into mem_* regs, go to ISSUE.
  - halt=1 and req_en=0: mem_createdump=1 for exactly one cycle, go to HALTED.
  - req_en and halt together: the request is serviced first; halt is acted on when back in IDLE.
- ISSUE:
  - mem_en=1 while mem_busy=1; stay in ISSUE. The counter does not advance here.
  - mem_busy=0: mem_en is sampled this cycle. Clear the counter and go to WAIT.
- WAIT:
  - mem_en=0. Counter increments each cycle.
  - mem_ack=1: rdata<=mem_rdata on loads; on stores rdata is unchanged. Go to DONE.
  - mem_ack on the same cycle the counter reaches TIMEOUT-1: ack wins.
  - Counter reaches TIMEOUT-1 with no ack: err<=1, rdata<=0x0000, go to DONE.
- DONE: done=1, stall=0, pipeline advances. Always go to IDLE next. A request is never re-accepted from the same instruction.
- HALTED: terminal until reset. stall=1 permanently; mem_en=0.
- stall is combinational:
  - 1 in IDLE when req_en=1;
  - 1 in ISSUE, WAIT and HALTED;
  - 0 in IDLE when req_en=0, and 0 in DONE.
- Minimum access latency: 3 cycles from request to done (IDLE→ISSUE→WAIT with same-cycle ack→DONE), with no busy and ack in the first WAIT cycle.
- Back-to-back accesses: the next req_en is seen in the cycle after DONE.
- err never clears except on reset.
- mem_ack outside WAIT is ignored.
- rst asserted mid-transaction: immediate return to IDLE and all outputs 0. No memory cleanup is performed.

Decomposition:
- Shared processor package holds the state encoding constants (IDLE=3'd0, ISSUE=3'd1, WAIT=3'd2, DONE=3'd3, HALTED=3'd4) and DATA_W=16.
- One natural sub-module, dmem_timeout_cnt: a CNT_W-bit counter with clear/enable inputs and an expired output at TIMEOUT-1.

Test Plan:
- Aligned load, addr 0x0010, mem_busy=0, ack 2 cycles after entering WAIT with mem_rdata=0xBEEF → stall high 4 cycles, then done pulse, rdata=0xBEEF, err=0.
- Store, addr 0x0020, wdata 0x1234, mem_busy high 3 cycles → mem_en held 4 cycles with mem_wr=1, mem_addr=0x0020, mem_wdata=0x1234. done after ack; rdata unchanged.
- Unaligned load, addr 0x0021 → mem_en never asserted. done on cycle 2, rdata=0x0000, err=1 and remains 1 through subsequent good accesses.
- No ack for 64 cycles in WAIT → done at cycle 64, err=1, rdata=0x0000. Repeat with ack exactly at count 63 → err=0, data returned.
- halt=1 with req_en=0 in IDLE → mem_createdump high exactly one cycle, stall stays high forever, mem_en=0. Reset low → all outputs 0, IDLE.
- Reset pulsed low during WAIT → outputs 0 asynchronously. After release, a new load completes normally with err=0.

Source files
------------

// File: rtl/dmem_stall_ctrl_pkg.sv
// Shared memory-stage definitions: controller state encoding, datapath width
// and the alignment helper.
package dmem_stall_ctrl_pkg;

   localparam int unsigned DATA_W = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE  = 3'd1,
      WAIT   = 3'd2,
      DONE   = 3'd3,
      HALTED = 3'd4
   } state_t;

   function automatic logic is_unaligned(input logic [DATA_W-1:0] addr);
      return addr[0];
   endfunction

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Cycle counter for the memory wait phase; expired is high while the count
// sits at TIMEOUT-1.
module dmem_timeout_cnt #(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = 7
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_stall_ctrl.sv
// Memory-stage request controller: turns a single-cycle request into a
// busy/ack memory transaction and stalls the pipeline until it completes.
module dmem_stall_ctrl
   import dmem_stall_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_en,
   input  logic              req_wr,
   input  logic [DATA_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic              halt,
   output logic              stall,
   output logic              done,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_createdump,
   input  logic              mem_busy,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   // Reset asserts immediately but is released two clocks later, on an edge.
   logic [1:0] rst_sync;
   logic       rst_ok;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rst_sync <= '0;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign rst_ok = rst_sync[1];

   state_t            state_q, state_d;
   logic              cnt_clr, cnt_en, expired;
   logic              latch_req, rdata_ld, set_err;
   logic [DATA_W-1:0] rdata_d;
   logic              stall_c, dump_c;

   dmem_timeout_cnt #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_timeout_cnt (
      .clk     (clk),
      .rst_n   (rst_ok),
      .clr     (cnt_clr),
      .en      (cnt_en),
      .expired (expired)
   );

   always_comb begin
      state_d   = state_q;
      stall_c   = 1'b0;
      dump_c    = 1'b0;
      done      = 1'b0;
      mem_en    = 1'b0;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;
      latch_req = 1'b0;
      rdata_ld  = 1'b0;
      rdata_d   = '0;
      set_err   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_en) begin
               stall_c = 1'b1;
               if (is_unaligned(req_addr)) begin
                  set_err  = 1'b1;
                  rdata_ld = 1'b1;
                  state_d  = DONE;
               end else begin
                  latch_req = 1'b1;
                  state_d   = ISSUE;
               end
            end else if (halt) begin
               dump_c  = 1'b1;
               state_d = HALTED;
            end
         end
         ISSUE: begin
            stall_c = 1'b1;
            mem_en  = 1'b1;
            if (!mem_busy) begin
               cnt_clr = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            stall_c = 1'b1;
            cnt_en  = 1'b1;
            // An ack in the expiry cycle still completes the access normally.
            if (mem_ack) begin
               rdata_ld = !mem_wr;
               rdata_d  = mem_rdata;
               state_d  = DONE;
            end else if (expired) begin
               set_err  = 1'b1;
               rdata_ld = 1'b1;
               state_d  = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         HALTED: begin
            stall_c = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // IDLE-state outputs depend on live inputs, so they are masked during reset.
   assign stall          = stall_c & rst_ok;
   assign mem_createdump = dump_c & rst_ok;

   always_ff @(posedge clk or negedge rst_ok) begin
      if (!rst_ok) begin
         state_q   <= IDLE;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rdata     <= '0;
         err       <= 1'b0;
      end else begin
         state_q <= state_d;
         if (latch_req) begin
            mem_wr    <= req_wr;
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
         end
         if (rdata_ld) begin
            rdata <= rdata_d;
         end
         if (set_err) begin
            err <= 1'b1;
         end
      end
   end

endmodule
